axi_lite_mem_slave: RTL
=======================

AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

Interface
- REQ-001: Parameter MEM_WORDS, default 1024, memory depth in 32-bit words; power of two, at least 2.
- REQ-002: Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: axi_araddr in 32 read address; axi_arvalid in 1; axi_arready out 1; axi_arprot in 3 (ignored).
- REQ-006: axi_rdata out 32 read data; axi_rresp out 2; axi_rvalid out 1; axi_rready in 1.
- REQ-007: axi_awaddr in 32 write address; axi_awvalid in 1; axi_awready out 1; axi_awprot in 3 (ignored).
- REQ-008: axi_wdata in 32; axi_wstrb in 4 byte enables; axi_wvalid in 1; axi_wready out 1.
- REQ-009: axi_bresp out 2 write response; axi_bvalid out 1; axi_bready in 1.

Function
- REQ-010: The block SHALL be an AXI4-Lite responder backed by a MEM_WORDS x 32 array; read and write channels operate independently and concurrently.
- REQ-011: A handshake occurs on a rising edge where valid and ready are both 1; the block never lowers a valid before its handshake.
- REQ-012: Decode: offset = addr - BASE_ADDR (32-bit unsigned wrap); hit if offset < MEM_WORDS*4; word index = offset[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
- REQ-013: Read FSM states R_IDLE, R_RESP; in R_IDLE, axi_arready=1, axi_rvalid=0.
- REQ-014: R_IDLE -> R_RESP on AR handshake; axi_rvalid=1 and axi_rdata valid on the next cycle (latency 1).
- REQ-015: Hit: rresp=2'b00 (OKAY), rdata=array word; miss: rresp=2'b11 (DECERR), rdata=0.
- REQ-016: In R_RESP, arready=0; rdata/rresp held stable until R handshake, then -> R_IDLE; no back-to-back AR acceptance in the handshake cycle.
- REQ-017: Write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP; W_IDLE: awready=1, wready=1, bvalid=0.
- REQ-018: W_IDLE: AW and W same cycle -> commit, -> W_RESP; AW only -> latch addr, -> W_HAVE_A; W only -> latch data/strb, -> W_HAVE_D.
- REQ-019: W_HAVE_A: awready=0, wready=1; on W handshake commit, -> W_RESP. W_HAVE_D: wready=0, awready=1; on AW handshake commit, -> W_RESP.
- REQ-020: Commit: on hit, write byte i of the word iff wstrb[i]; strb=0 writes nothing; on miss, no array change.
- REQ-021: W_RESP: bvalid=1, bresp=2'b00 hit / 2'b11 miss, awready=wready=0; on B handshake -> W_IDLE.
- REQ-022: Write commit and read sample of the same word in the same edge: read returns pre-write data.
- REQ-023: Stalled rready/bready held indefinitely SHALL not lose or alter the pending response.

Reset
- REQ-024: While rst=1 at a rising edge, both FSMs go to idle; rvalid=0, bvalid=0, rresp=bresp=0, rdata=0; arready/awready/wready=1 from the first cycle after reset.
- REQ-025: Reset mid-transaction discards latched address/data and any pending response without array write; array contents not reset.

Structure
- REQ-026: Shared package holds resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11 and the read/write FSM state enums.
- REQ-027: One sub-module natural: axi_lite_mem_array (one read port, one byte-enabled write port, synchronous read, BRAM-inferable).

Verification
- REQ-028: AW+W same cycle addr 0x10, data 0xDEADBEEF, strb 4'hF, bready=1 -> bvalid next cycle, bresp 00; AR 0x10 -> rdata 0xDEADBEEF, rresp 00, rvalid 1 cycle after AR.
- REQ-029: W first (0x11223344, strb 4'b0101), AW 3 cycles later to 0x10 holding 0xDEADBEEF -> read returns 0xDE22BE44.
- REQ-030: AR to BASE_ADDR+MEM_WORDS*4 -> rresp 11, rdata 0; write there -> bresp 11, array unchanged.
- REQ-031: rready=0 for 5 cycles after rvalid -> rvalid, rdata, rresp stable, arready=0 throughout.
- REQ-032: Write commit and AR to same word in same cycle -> old data returned; next read returns new data.
- REQ-033: rst=1 while in W_HAVE_A -> no bvalid; after reset, idle readies all 1; subsequent write completes normally.

Source files
------------

// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared definitions for the AXI4-Lite memory responder.
//   - AXI response codes
//   - read and write channel FSM state encodings
package axi_lite_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word-addressed storage behind the AXI4-Lite responder.
//   clk     : clock
//   rd_en   : capture mem[rd_idx] into rd_data at the rising edge
//   rd_idx  : read word index
//   rd_data : registered read data, held while rd_en is low
//   wr_en   : write enable
//   wr_idx  : write word index
//   wr_data : write data
//   wr_strb : per-byte write enables
// A read and a write to the same word on the same edge return the old word.
module axi_lite_mem_array #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a MEM_WORDS x 32 memory.
//   clk, rst          : clock, synchronous active-high reset
//   axi_ar*           : read address channel (arprot ignored)
//   axi_r*            : read data channel, one cycle after AR handshake
//   axi_aw*, axi_w*   : write address / data channels, accepted in any order
//   axi_b*            : write response channel
// Addresses outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*4) answer DECERR;
// reads then return zero and writes leave the memory untouched.
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int          IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) * 33'd4;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  function automatic logic addr_hit(input logic [31:0] addr);
    return ({1'b0, 32'(addr - BASE_ADDR)} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{axi_arprot, axi_awprot};

  rd_state_t   rd_state;
  logic        rd_hit_q;
  logic        rd_en;
  logic [31:0] arr_rdata;

  wr_state_t   wr_state;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        commit;
  logic        commit_hit;
  logic        wr_en;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;

  // Read: memory is sampled on the AR handshake edge.
  assign rd_en = (rd_state == R_IDLE) && axi_arvalid && !rst;

  // Array data stays put until the next AR handshake, so masking by the
  // registered hit flag keeps rdata stable for the whole response.
  assign axi_rdata = rd_hit_q ? arr_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= R_IDLE;
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      rd_hit_q    <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (axi_arvalid) begin
            rd_state    <= R_RESP;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b1;
            rd_hit_q    <= addr_hit(axi_araddr);
            axi_rresp   <= addr_hit(axi_araddr) ? RESP_OKAY : RESP_DECERR;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            rd_state    <= R_IDLE;
            axi_arready <= 1'b1;
            axi_rvalid  <= 1'b0;
          end
        end
        default: begin
          rd_state    <= R_IDLE;
          axi_arready <= 1'b1;
          axi_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Write: the commit happens on the edge where the second of AW/W arrives.
  always_comb begin
    commit      = 1'b0;
    commit_addr = axi_awaddr;
    commit_data = axi_wdata;
    commit_strb = axi_wstrb;
    case (wr_state)
      W_IDLE: begin
        commit = axi_awvalid && axi_wvalid;
      end
      W_HAVE_A: begin
        commit      = axi_wvalid;
        commit_addr = aw_addr_q;
      end
      W_HAVE_D: begin
        commit      = axi_awvalid;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  assign commit_hit = addr_hit(commit_addr);
  assign wr_en      = commit && commit_hit && !rst;

  // Latched address/data are left unreset: returning to W_IDLE discards them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= W_IDLE;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (commit) begin
            wr_state    <= W_RESP;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b1;
            axi_bresp   <= commit_hit ? RESP_OKAY : RESP_DECERR;
          end else if (axi_awvalid) begin
            wr_state    <= W_HAVE_A;
            aw_addr_q   <= axi_awaddr;
            axi_awready <= 1'b0;
          end else if (axi_wvalid) begin
            wr_state    <= W_HAVE_D;
            w_data_q    <= axi_wdata;
            w_strb_q    <= axi_wstrb;
            axi_wready  <= 1'b0;
          end
        end
        W_HAVE_A, W_HAVE_D: begin
          if (commit) begin
            wr_state    <= W_RESP;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b1;
            axi_bresp   <= commit_hit ? RESP_OKAY : RESP_DECERR;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            wr_state    <= W_IDLE;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            axi_bvalid  <= 1'b0;
          end
        end
        default: begin
          wr_state <= W_IDLE;
        end
      endcase
    end
  end

  axi_lite_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (addr_idx(axi_araddr)),
    .rd_data (arr_rdata),
    .wr_en   (wr_en),
    .wr_idx  (addr_idx(commit_addr)),
    .wr_data (commit_data),
    .wr_strb (commit_strb)
  );

endmodule
